dds_param_scheduler: RTL

DDS_PARAM_SCHEDULER -- requirements
Module: dds_param_scheduler

---
 rtl/dds_pkg.sv | 57 +++++
 rtl/dds_rr_pick.sv | 34 +++
 rtl/dds_param_scheduler.sv | 129 ++++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// Shared constants, FSM encoding and item-index decode for the DDS parameter scheduler.
// An item index is ch*3 + kind, where kind is 0 = FTW, 1 = POW and 2 = ACR.
package dds_pkg;

  localparam int ITEMS = 12;
  localparam int NUM_CH = 4;

  localparam logic [7:0] ADDR_FTW = 8'h04;
  localparam logic [7:0] ADDR_POW = 8'h05;
  localparam logic [7:0] ADDR_ACR = 8'h06;

  localparam logic [2:0] LEN_FTW = 3'd4;
  localparam logic [2:0] LEN_POW = 3'd2;
  localparam logic [2:0] LEN_ACR = 3'd3;

  localparam logic [3:0] LAST_ITEM = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  function automatic logic [1:0] item_ch(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1, 4'd2:  item_ch = 2'd0;
      4'd3, 4'd4, 4'd5:  item_ch = 2'd1;
      4'd6, 4'd7, 4'd8:  item_ch = 2'd2;
      default:           item_ch = 2'd3;
    endcase
  endfunction

  function automatic logic [1:0] item_kind(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd3, 4'd6, 4'd9:  item_kind = 2'd0;
      4'd1, 4'd4, 4'd7, 4'd10: item_kind = 2'd1;
      default:                 item_kind = 2'd2;
    endcase
  endfunction

  function automatic logic [7:0] item_addr(input logic [3:0] idx);
    case (item_kind(idx))
      2'd0:    item_addr = ADDR_FTW;
      2'd1:    item_addr = ADDR_POW;
      default: item_addr = ADDR_ACR;
    endcase
  endfunction

  function automatic logic [2:0] item_len(input logic [3:0] idx);
    case (item_kind(idx))
      2'd0:    item_len = LEN_FTW;
      2'd1:    item_len = LEN_POW;
      default: item_len = LEN_ACR;
    endcase
  endfunction

endpackage

// File: rtl/dds_rr_pick.sv
// Round-robin picker: first dirty item after 'last', wrapping 11 -> 0.
// 'last' itself is the final candidate, so a lone re-dirtied item can be picked again.
module dds_rr_pick
  import dds_pkg::*;
(
  input  logic [ITEMS-1:0] dirty,
  input  logic [3:0]       last,
  output logic             found,
  output logic [3:0]       next_idx
);

  logic [3:0]       cand [ITEMS];
  logic [ITEMS-1:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < ITEMS; gi++) begin : g_cand
      logic [4:0] sum;
      assign sum       = {1'b0, last} + 5'(gi + 1);
      assign cand[gi]  = (sum >= 5'(ITEMS)) ? 4'(sum - 5'(ITEMS)) : sum[3:0];
      assign hit[gi]   = dirty[cand[gi]];
    end
  endgenerate

  // Scan from the farthest candidate down so the nearest hit wins.
  always_comb begin
    found    = |hit;
    next_idx = 4'd0;
    for (int k = ITEMS - 1; k >= 0; k--) begin
      if (hit[k]) next_idx = cand[k];
    end
  end

endmodule

// File: rtl/dds_param_scheduler.sv
// Tracks 12 DDS parameter items against shadows and issues dirty ones as register writes,
// closing each batch of writes with a single IO_UPDATE request.
module dds_param_scheduler
  import dds_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] frq0,
  input  logic [31:0] frq1,
  input  logic [31:0] frq2,
  input  logic [31:0] frq3,
  input  logic [15:0] phase0,
  input  logic [15:0] phase1,
  input  logic [15:0] phase2,
  input  logic [15:0] phase3,
  input  logic [23:0] amp0,
  input  logic [23:0] amp1,
  input  logic [23:0] amp2,
  input  logic [23:0] amp3,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [1:0]  req_ch,
  output logic [7:0]  req_addr,
  output logic [31:0] req_data,
  output logic [2:0]  req_len,
  output logic        upd_valid,
  input  logic        upd_ready,
  output logic        busy
);

  logic [31:0] frq_arr   [NUM_CH];
  logic [15:0] phase_arr [NUM_CH];
  logic [23:0] amp_arr   [NUM_CH];
  logic [31:0] in_val    [ITEMS];
  logic [31:0] shadow_reg [ITEMS];

  logic [ITEMS-1:0] dirty_reg, dirty_next, diff;
  state_t      state_reg, state_next;
  logic [3:0]  cur_reg, last_reg, pick_idx;
  logic        pick_found, req_hs, upd_hs, load;
  logic [1:0]  req_ch_reg;
  logic [7:0]  req_addr_reg;
  logic [31:0] req_data_reg;
  logic [2:0]  req_len_reg;
  logic        unused_phase_hi;

  assign frq_arr   = '{frq0, frq1, frq2, frq3};
  assign phase_arr = '{phase0, phase1, phase2, phase3};
  assign amp_arr   = '{amp0, amp1, amp2, amp3};
  assign unused_phase_hi = ^{phase0[15:14], phase1[15:14], phase2[15:14], phase3[15:14]};

  assign req_hs = (state_reg == ST_ISSUE) && req_ready;
  assign upd_hs = (state_reg == ST_UPDATE) && upd_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
      assign in_val[gi*3]     = frq_arr[gi];
      assign in_val[gi*3 + 1] = {18'd0, phase_arr[gi][13:0]};
      assign in_val[gi*3 + 2] = {8'd0, amp_arr[gi]};
    end
    // The in-flight item compares against what was actually sent, so a change
    // during the stall leaves it dirty for a reissue.
    for (gi = 0; gi < ITEMS; gi++) begin : g_dirty
      assign diff[gi]       = in_val[gi] != shadow_reg[gi];
      assign dirty_next[gi] = (req_hs && cur_reg == 4'(gi)) ? (in_val[gi] != req_data_reg)
                                                           : (dirty_reg[gi] | diff[gi]);
    end
  endgenerate

  dds_rr_pick u_pick (
    .dirty    (dirty_next),
    .last     (last_reg),
    .found    (pick_found),
    .next_idx (pick_idx)
  );

  assign load = pick_found && ((state_reg == ST_IDLE) || req_hs);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (pick_found) state_next = ST_ISSUE;
      ST_ISSUE:  if (req_hs)     state_next = pick_found ? ST_ISSUE : ST_UPDATE;
      ST_UPDATE: if (upd_hs)     state_next = ST_IDLE;
      default:                   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_valid = (state_reg == ST_ISSUE);
    upd_valid = (state_reg == ST_UPDATE);
    busy      = (state_reg != ST_IDLE) || (|dirty_reg);
    req_ch    = req_ch_reg;
    req_addr  = req_addr_reg;
    req_data  = req_data_reg;
    req_len   = req_len_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dirty_reg    <= '1;
      last_reg     <= LAST_ITEM;
      cur_reg      <= '0;
      req_ch_reg   <= '0;
      req_addr_reg <= '0;
      req_data_reg <= '0;
      req_len_reg  <= '0;
      for (int i = 0; i < ITEMS; i++) shadow_reg[i] <= '0;
    end else begin
      dirty_reg <= dirty_next;
      if (req_hs) shadow_reg[cur_reg] <= req_data_reg;
      if (load) begin
        cur_reg      <= pick_idx;
        last_reg     <= pick_idx;
        req_ch_reg   <= item_ch(pick_idx);
        req_addr_reg <= item_addr(pick_idx);
        req_len_reg  <= item_len(pick_idx);
        req_data_reg <= in_val[pick_idx];
      end
    end
  end

endmodule
